tx_arbiter: RTL and testbench

Round-robin scheduler that shares one `TX` serializer between `NREQ` requesters. It accepts a byte from one requester at a time and drives `TX_RQ`/`TXDATA` into `TX`. It then tracks `TX_BUSY` through the frame and reports grant, completion and a sticky start-timeout error. It sits directly in front of `TX`, and `TXC` is shared with it.

---
 rtl/tx_arbiter.sv | 172 +++++++++++++++++
 tb/tb_tx_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin front end that shares one TX serializer between
// NREQ requesters. It latches one byte per grant, holds TX_RQ/TXDATA until
// TX accepts the frame, waits out TX_BUSY, then reports DONE. If TX never
// starts the frame, the byte is dropped and a sticky ERR flag is raised.
module tx_arbiter #(
    parameter int unsigned SIZE    = 8,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                     TXC,
    input  logic                     RST,
    input  logic [NREQ-1:0]          REQ,
    input  logic [NREQ*SIZE-1:0]     REQ_DATA,
    output logic [NREQ-1:0]          GNT,
    output logic                     DONE,
    output logic [$clog2(NREQ)-1:0]  ACTIVE_ID,
    output logic                     ERR,
    output logic                     TX_RQ,
    output logic [SIZE-1:0]          TXDATA,
    input  logic                     TX_BUSY
);

    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned CW  = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE
    } state_t;

    // Registered state
    state_t          r_state;
    logic [IDW-1:0]  r_last;
    logic [CW-1:0]   r_cnt;
    logic            r_tx_rq;
    logic [SIZE-1:0] r_txdata;
    logic [NREQ-1:0] r_gnt;
    logic            r_done;
    logic [IDW-1:0]  r_active_id;
    logic            r_err;

    // Next-state values
    state_t          w_state_nx;
    logic [IDW-1:0]  w_last_nx;
    logic [CW-1:0]   w_cnt_nx;
    logic            w_tx_rq_nx;
    logic [SIZE-1:0] w_txdata_nx;
    logic [NREQ-1:0] w_gnt_nx;
    logic            w_done_nx;
    logic [IDW-1:0]  w_active_id_nx;
    logic            w_err_nx;

    // Arbitration result
    logic            w_found;
    logic [IDW-1:0]  w_win;
    logic [IDW-1:0]  w_cand;
    logic [SIZE-1:0] w_win_data;

    // Index base+off reduced modulo NREQ (off never exceeds NREQ).
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base,
                                                input int unsigned    off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IDW'(s);
    endfunction

    // Round-robin search: first pending requester above LAST, wrapping.
    always_comb begin
        w_found    = 1'b0;
        w_win      = '0;
        w_cand     = '0;
        w_win_data = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_cand = wrap_idx(r_last, k);
            if (!w_found && REQ[w_cand]) begin
                w_found    = 1'b1;
                w_win      = w_cand;
                w_win_data = REQ_DATA[w_cand*SIZE +: SIZE];
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_state_nx     = r_state;
        w_last_nx      = r_last;
        w_cnt_nx       = r_cnt;
        w_tx_rq_nx     = r_tx_rq;
        w_txdata_nx    = r_txdata;
        w_gnt_nx       = '0;
        w_done_nx      = 1'b0;
        w_active_id_nx = r_active_id;
        w_err_nx       = r_err;

        case (r_state)
            S_IDLE: begin
                // A still-draining frame holds off the next grant.
                if (w_found && !TX_BUSY) begin
                    w_txdata_nx     = w_win_data;
                    w_tx_rq_nx      = 1'b1;
                    w_gnt_nx[w_win] = 1'b1;
                    w_active_id_nx  = w_win;
                    w_last_nx       = w_win;
                    w_cnt_nx        = '0;
                    w_state_nx      = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (TX_BUSY) begin
                    w_tx_rq_nx = 1'b0;
                    w_state_nx = S_WAIT_DONE;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    // TX never accepted the byte: drop it and flag.
                    w_tx_rq_nx = 1'b0;
                    w_err_nx   = 1'b1;
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end

            S_WAIT_DONE: begin
                if (!TX_BUSY) begin
                    w_done_nx  = 1'b1;
                    w_state_nx = S_IDLE;
                end
            end

            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // State and output registers; LAST resets to NREQ-1 so requester 0 wins first.
    always_ff @(posedge TXC or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_last      <= IDW'(NREQ - 1);
            r_cnt       <= '0;
            r_tx_rq     <= 1'b0;
            r_txdata    <= '0;
            r_gnt       <= '0;
            r_done      <= 1'b0;
            r_active_id <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_last      <= w_last_nx;
            r_cnt       <= w_cnt_nx;
            r_tx_rq     <= w_tx_rq_nx;
            r_txdata    <= w_txdata_nx;
            r_gnt       <= w_gnt_nx;
            r_done      <= w_done_nx;
            r_active_id <= w_active_id_nx;
            r_err       <= w_err_nx;
        end
    end

    assign GNT       = r_gnt;
    assign DONE      = r_done;
    assign ACTIVE_ID = r_active_id;
    assign ERR       = r_err;
    assign TX_RQ     = r_tx_rq;
    assign TXDATA    = r_txdata;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter with a behavioural TX model and a grant scoreboard.
module tb_tx_arbiter;

    localparam int unsigned SIZE    = 8;
    localparam int unsigned NREQ    = 4;
    localparam int unsigned TIMEOUT = 16;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    logic                 TXC = 1'b0;
    logic                 RST = 1'b1;
    logic [NREQ-1:0]      REQ = '0;
    logic [NREQ*SIZE-1:0] REQ_DATA = '0;
    logic [NREQ-1:0]      GNT;
    logic                 DONE;
    logic [1:0]           ACTIVE_ID;
    logic                 ERR;
    logic                 TX_RQ;
    logic [SIZE-1:0]      TXDATA;
    logic                 TX_BUSY = 1'b0;

    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   done_cnt = 0;
    bit   saw_gnt  = 1'b0;
    int   tx_mode  = 0;     // 0 normal TX, 1 busy tied low, 2 busy forced high
    int   fcnt     = 0;
    int   rq_cnt   = 0;
    exp_t exp_q[$];

    tx_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .TXC       (TXC),
        .RST       (RST),
        .REQ       (REQ),
        .REQ_DATA  (REQ_DATA),
        .GNT       (GNT),
        .DONE      (DONE),
        .ACTIVE_ID (ACTIVE_ID),
        .ERR       (ERR),
        .TX_RQ     (TX_RQ),
        .TXDATA    (TXDATA),
        .TX_BUSY   (TX_BUSY)
    );

    always #5 TXC = ~TXC;

    // TX model: busy rises one edge after TX_RQ and stays high for 10 cycles.
    always @(posedge TXC) begin
        case (tx_mode)
            1: begin TX_BUSY <= 1'b0; fcnt <= 0; end
            2: begin TX_BUSY <= 1'b1; fcnt <= 0; end
            default: begin
                if (TX_BUSY) begin
                    if (fcnt <= 1) TX_BUSY <= 1'b0;
                    else           fcnt <= fcnt - 1;
                end else if (TX_RQ) begin
                    TX_BUSY <= 1'b1;
                    fcnt    <= 10;
                end
            end
        endcase
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample on the falling edge, and score any grant.
    task automatic step();
        exp_t       e;
        logic [3:0] oh;
        @(negedge TXC);
        if (DONE === 1'b1) done_cnt++;
        if (GNT !== 4'b0000) begin
            saw_gnt = 1'b1;
            if (exp_q.size() == 0) begin
                chk("unexpected_gnt", 32'(GNT), 32'd0);
            end else begin
                e = exp_q.pop_front();
                oh = 4'b0000;
                oh[e.id] = 1'b1;
                chk("gnt_onehot", 32'(GNT), 32'(oh));
                chk("active_id", 32'(ACTIVE_ID), 32'(e.id));
                chk("txdata", 32'(TXDATA), 32'(e.data));
                chk("tx_rq_at_gnt", 32'(TX_RQ), 32'd1);
            end
        end
    endtask

    task automatic wait_gnt(input string tag);
        saw_gnt = 1'b0;
        for (int i = 0; i < 60 && !saw_gnt; i++) step();
        chk(tag, 32'(saw_gnt), 32'd1);
    endtask

    task automatic wait_busy(input logic level, input string tag);
        for (int i = 0; i < 60 && TX_BUSY !== level; i++) step();
        chk(tag, 32'(TX_BUSY), 32'(level));
    endtask

    task automatic wait_drain(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
        chk({tag, "_all_granted"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_done_cnt(input int target, input string tag);
        for (int i = 0; i < 400 && done_cnt < target; i++) step();
        repeat (2) step();
        chk(tag, 32'(done_cnt), 32'(target));
    endtask

    task automatic push(input logic [1:0] id, input logic [7:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        exp_q.push_back(e);
    endtask

    initial begin
        // Reset state
        repeat (2) step();
        chk("rst_gnt", 32'(GNT), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_active_id", 32'(ACTIVE_ID), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        chk("rst_tx_rq", 32'(TX_RQ), 32'd0);
        chk("rst_txdata", 32'(TXDATA), 32'd0);
        RST = 1'b0;

        // Round-robin with all four requesters held
        done_cnt = 0;
        REQ_DATA = {8'h13, 8'h12, 8'h11, 8'h10};
        push(2'd0, 8'h10); push(2'd1, 8'h11); push(2'd2, 8'h12);
        push(2'd3, 8'h13); push(2'd0, 8'h10);
        REQ = 4'b1111;
        wait_drain(5, 300, "rr");
        REQ = 4'b0000;
        wait_done_cnt(5, "rr_done_count");

        // Wrap and skip: grant 3, then 1001 yields 0 then 3
        done_cnt = 0;
        push(2'd3, 8'h13);
        REQ = 4'b1000;
        wait_drain(1, 60, "wrap_first");
        push(2'd0, 8'h10); push(2'd3, 8'h13);
        REQ = 4'b1001;
        wait_drain(2, 120, "wrap");
        REQ = 4'b0000;
        wait_done_cnt(3, "wrap_done_count");

        // Single requester with detailed handshake timing
        done_cnt = 0;
        REQ_DATA = {8'h13, 8'h12, 8'hA5, 8'h10};
        push(2'd1, 8'hA5);
        REQ = 4'b0010;
        wait_gnt("single_gnt_seen");
        REQ = 4'b0000;
        step();
        chk("single_gnt_pulse", 32'(GNT), 32'd0);
        wait_busy(1'b1, "single_busy_rise");
        chk("single_rq_held", 32'(TX_RQ), 32'd1);
        step();
        chk("single_rq_fall", 32'(TX_RQ), 32'd0);
        wait_busy(1'b0, "single_busy_fall");
        chk("single_done_pre", 32'(DONE), 32'd0);
        step();
        chk("single_done", 32'(DONE), 32'd1);
        step();
        chk("single_done_pulse", 32'(DONE), 32'd0);
        wait_done_cnt(1, "single_done_count");

        // Start timeout with TX_BUSY tied low
        done_cnt = 0;
        tx_mode  = 1;
        REQ_DATA = {8'h13, 8'h12, 8'h11, 8'h10};
        push(2'd0, 8'h10);
        REQ = 4'b0001;
        wait_gnt("to_gnt_seen");
        rq_cnt = 1;
        for (int i = 0; i < 40 && TX_RQ === 1'b1; i++) begin
            step();
            if (TX_RQ === 1'b1) rq_cnt++;
        end
        chk("to_rq_cycles", 32'(rq_cnt), 32'd16);
        chk("to_err_set", 32'(ERR), 32'd1);
        chk("to_no_done", 32'(done_cnt), 32'd0);
        push(2'd0, 8'h10);
        wait_gnt("to_regrant");
        REQ = 4'b0000;
        for (int i = 0; i < 40 && TX_RQ === 1'b1; i++) step();
        chk("to_err_sticky", 32'(ERR), 32'd1);
        chk("to_no_done_2", 32'(done_cnt), 32'd0);
        tx_mode = 0;

        // Drain hold-off: busy high in IDLE blocks arbitration
        done_cnt = 0;
        tx_mode  = 2;
        repeat (2) step();
        REQ = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("holdoff_gnt", 32'(GNT), 32'd0);
            chk("holdoff_rq", 32'(TX_RQ), 32'd0);
        end
        push(2'd2, 8'h12);
        tx_mode = 0;
        step();
        chk("drain_busy_low", 32'(TX_BUSY), 32'd0);
        chk("drain_no_gnt_yet", 32'(GNT), 32'd0);
        saw_gnt = 1'b0;
        step();
        chk("drain_gnt_next_edge", 32'(saw_gnt), 32'd1);
        REQ = 4'b0000;
        wait_done_cnt(1, "drain_done_count");

        // Mid-frame reset while in WAIT_DONE
        done_cnt = 0;
        push(2'd1, 8'h11);
        REQ = 4'b0010;
        wait_gnt("mr_gnt_seen");
        REQ = 4'b0000;
        wait_busy(1'b1, "mr_busy_rise");
        repeat (2) step();
        chk("mr_in_wait_done", 32'(TX_RQ), 32'd0);
        RST = 1'b1;
        #1;
        chk("mr_tx_rq", 32'(TX_RQ), 32'd0);
        chk("mr_txdata", 32'(TXDATA), 32'd0);
        chk("mr_gnt", 32'(GNT), 32'd0);
        chk("mr_err", 32'(ERR), 32'd0);
        chk("mr_active_id", 32'(ACTIVE_ID), 32'd0);
        wait_busy(1'b0, "mr_tx_drained");
        step();
        push(2'd0, 8'h10);
        REQ = 4'b1111;
        RST = 1'b0;
        saw_gnt = 1'b0;
        step();
        chk("mr_first_gnt", 32'(saw_gnt), 32'd1);
        chk("mr_no_done", 32'(done_cnt), 32'd0);
        REQ = 4'b0000;
        wait_done_cnt(1, "mr_done_count");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
